// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 single-bit mux.
// It adds a per-owner hold limit and registers the selected bit with a valid flag.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] req_in,
  input  logic [3:0] data_in,
  output logic [3:0] grant_out,
  output logic [1:0] sel_out,
  output logic       y_out,
  output logic       valid_out
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [3:0] eligible;
  logic       win_found;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       at_limit;
  logic       take_new;
  logic       go_idle;

  // While granted, the current owner never competes in the scan.
  always_comb begin
    eligible = req_in;
    if (state == GRANT) begin
      eligible = req_in & ~(4'b0001 << sel_out);
    end
  end

  // Circular scan starting one past the last winner; wraps naturally in 2 bits.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && eligible[ptr + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    owner_req = req_in[sel_out];
    at_limit  = (hold_cnt == HOLD_LAST);
    take_new  = 1'b0;
    go_idle   = 1'b0;
    if (state == IDLE) begin
      take_new = win_found;
    end else if (!owner_req) begin
      take_new = win_found;
      go_idle  = !win_found;
    end else if (at_limit) begin
      take_new = win_found;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      hold_cnt  <= '0;
      grant_out <= 4'b0000;
      sel_out   <= 2'd0;
      y_out     <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      // Output stage lags the grant by one cycle and is zero when not granted.
      valid_out <= (state == GRANT);
      y_out     <= (state == GRANT) ? data_in[sel_out] : 1'b0;

      if (take_new) begin
        state     <= GRANT;
        grant_out <= 4'b0001 << win_idx;
        sel_out   <= win_idx;
        ptr       <= win_idx;
        hold_cnt  <= '0;
      end else if (go_idle) begin
        state     <= IDLE;
        grant_out <= 4'b0000;
        hold_cnt  <= '0;
      end else if (state == GRANT) begin
        hold_cnt <= at_limit ? '0 : hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (hold limit 4 and 1) share stimulus
// and are compared every cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] data = 4'b0000;

  logic [3:0] g4, g1;
  logic [1:0] s4, s1;
  logic       y4, y1, v4, v1;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .req_in(req), .data_in(data),
    .grant_out(g4), .sel_out(s4), .y_out(y4), .valid_out(v4)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk_in(clk), .rst_in(rst), .req_in(req), .data_in(data),
    .grant_out(g1), .sel_out(s1), .y_out(y1), .valid_out(v1)
  );

  int checks   = 0;
  int failures = 0;

  // Model state per instance: owner index (-1 = idle), cycles held, last winner.
  int   m_owner [2];
  int   m_cnt   [2];
  int   m_last  [2];
  int   m_sel   [2];
  logic m_y     [2];
  logic m_v     [2];
  int   hold_lim[2] = '{4, 1};

  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_cnt[m]   = 0;
      m_last[m]  = 3;
      m_sel[m]   = 0;
      m_y[m]     = 1'b0;
      m_v[m]     = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    for (int m = 0; m < 2; m++) begin
      int w;
      w = -1;
      m_v[m] = (m_owner[m] >= 0);
      m_y[m] = (m_owner[m] >= 0) ? d[m_owner[m]] : 1'b0;
      if (m_owner[m] < 0) begin
        w = pick(r, m_last[m], -1);
      end else if (!r[m_owner[m]]) begin
        w = pick(r, m_last[m], m_owner[m]);
        if (w < 0) m_owner[m] = -1;
      end else if (m_cnt[m] == hold_lim[m] - 1) begin
        w = pick(r, m_last[m], m_owner[m]);
        if (w < 0) m_cnt[m] = 0;
      end else begin
        m_cnt[m] = m_cnt[m] + 1;
      end
      if (w >= 0) begin
        m_owner[m] = w;
        m_last[m]  = w;
        m_sel[m]   = w;
        m_cnt[m]   = 0;
      end
    end
  endtask

  task automatic check(input string tag, input string what,
                       input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s %s observed=%b expected=%b", tag, what, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] one;
    logic [3:0] eg4, eg1;
    one = 4'b0001;
    eg4 = (m_owner[0] < 0) ? 4'b0000 : (one << m_owner[0]);
    eg1 = (m_owner[1] < 0) ? 4'b0000 : (one << m_owner[1]);
    check(tag, "grant_h4", g4, eg4);
    check(tag, "sel_h4",   {2'b00, s4}, 4'(m_sel[0]));
    check(tag, "y_h4",     {3'b000, y4}, {3'b000, m_y[0]});
    check(tag, "valid_h4", {3'b000, v4}, {3'b000, m_v[0]});
    check(tag, "grant_h1", g1, eg1);
    check(tag, "sel_h1",   {2'b00, s1}, 4'(m_sel[1]));
    check(tag, "y_h1",     {3'b000, y1}, {3'b000, m_y[1]});
    check(tag, "valid_h1", {3'b000, v1}, {3'b000, m_v[1]});
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input string tag);
    @(negedge clk);
    req  = r;
    data = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cycle %s req=%b data=%b grant4=%b grant1=%b y4=%b v4=%b y1=%b v1=%b",
             tag, r, d, g4, g1, y4, v4, y1, v1);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    repeat (5) cycle(4'b0000, 4'($urandom), "idle");

    // Full contention: 0,1,2,3,0 four cycles each on the hold-4 instance.
    repeat (18) cycle(4'b1111, 4'b1010, "rr_full");

    // Single requester keeps the grant across hold wraps.
    repeat (10) cycle(4'b0100, 4'b0100, "single");

    // Owner 1 drops while 3 waits: direct hand-over without a bubble.
    cycle(4'b0000, 4'b0000, "to_idle");
    repeat (2) cycle(4'b0010, 4'b0010, "own1");
    repeat (2) cycle(4'b1000, 4'b1000, "drop_to3");

    // Asynchronous reset in the middle of owner 2's grant.
    cycle(4'b0000, 4'b0000, "to_idle2");
    repeat (3) cycle(4'b0100, 4'b0100, "own2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    req = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    model_step(4'b0101, 4'b0001);
    data = 4'b0001;
    @(posedge clk);
    #1;
    check_all("post_rst");
    $display("cycle post_rst req=0101 grant4=%b grant1=%b", g4, g1);
    repeat (3) cycle(4'b0101, 4'b0001, "post_rst_run");

    // Two-way contention: hold-1 instance alternates every cycle.
    repeat (8) cycle(4'b0011, 4'b0010, "alt");

    // Randomised traffic with occasional sticky request patterns.
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(3) == 0) r = 4'($urandom);
        cycle(r, 4'($urandom), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
